mpu_result_collector: RTL

Downstream stage of the matrix processor unit `mpu`: captures the 16-bit result stream the `mpu` emits on `data_out`/`send`. Packs result pairs into 32-bit host words and buffers them in a synchronous FIFO. The host drains the FIFO through a valid/ready port, so the `mpu` never stalls on a slow reader.

---
 rtl/mpu_pkg.sv | 24 ++
 rtl/mpu_result_collector_if.sv | 37 +++
 rtl/mpu_result_collector_fifo.sv | 76 +++++++
 rtl/mpu_result_collector.sv | 112 +++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// ---------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the matrix processor unit and its downstream stages.
//   MPU_DATA_W  width of one result produced by the mpu
//   HOST_W      width of one packed host word ({hi, lo})
//   packState_e packer state: PK_LO (no pending half), PK_HI (low half held)
//   hostWord_t  FIFO entry: partial tag plus the packed host word
// ---------------------------------------------------------------------------
package mpu_pkg;

   localparam int MPU_DATA_W = 16;
   localparam int HOST_W     = 32;

   typedef enum logic {
      PK_LO = 1'b0,
      PK_HI = 1'b1
   } packState_e;

   typedef struct packed {
      logic              partial;
      logic [HOST_W-1:0] data;
   } hostWord_t;

endpackage

// File: rtl/mpu_result_collector_if.sv
// ---------------------------------------------------------------------------
// mpu_result_collector_if
// Bundles the result stream from the mpu, the control strobes and the host
// drain port of mpu_result_collector.
//   data_in/send_in    result stream from mpu (one 16-bit result per cycle)
//   flush/clear_ovf    push pending half word / clear sticky overflow
//   out_data/out_partial/out_valid/out_ready  host valid/ready drain port
//   level/overflow     FIFO occupancy and sticky drop flag
// The slave modport is the collector's view; master is the driving side.
// ---------------------------------------------------------------------------
interface mpu_result_collector_if #(
   parameter int DEPTH = 16
);
   import mpu_pkg::*;

   logic [MPU_DATA_W-1:0]  data_in;
   logic                   send_in;
   logic                   flush;
   logic                   clear_ovf;
   logic [HOST_W-1:0]      out_data;
   logic                   out_partial;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;

   modport master (
      output data_in, send_in, flush, clear_ovf, out_ready,
      input  out_data, out_partial, out_valid, level, overflow
   );

   modport slave (
      input  data_in, send_in, flush, clear_ovf, out_ready,
      output out_data, out_partial, out_valid, level, overflow
   );

endinterface

// File: rtl/mpu_result_collector_fifo.sv
// ---------------------------------------------------------------------------
// mpu_result_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always
// presented on rdata_o; a pop advances the head on the accepting edge.
//   clock, reset   system clock, synchronous active-high reset
//   push_i/wdata_i write request and data (dropped when full without a pop)
//   pop_i          read request (ignored when empty)
//   rdata_o        head entry
//   level_o        occupancy 0..DEPTH
//   full_o/empty_o derived from level
// ---------------------------------------------------------------------------
module mpu_result_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 33
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W:0]   level_q;
   logic             popFire;
   logic             pushFire;

   // A full FIFO still accepts a write when the head leaves on the same edge,
   // so the write lands in the slot the pop frees up.
   always_comb begin
      full_o   = (level_q == (PTR_W+1)'(DEPTH));
      empty_o  = (level_q == '0);
      popFire  = pop_i && !empty_o;
      pushFire = push_i && (!full_o || popFire);
      rdata_o  = mem_q[rdPtr_q];
      level_o  = level_q;
   end

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (pushFire) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         if (popFire) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
         if (pushFire && !popFire) begin
            level_q <= level_q + (PTR_W+1)'(1);
         end else if (popFire && !pushFire) begin
            level_q <= level_q - (PTR_W+1)'(1);
         end
      end
   end

   // Storage needs no reset; stale entries are never visible because the
   // consumer masks the head when the FIFO is empty.
   always_ff @(posedge clock) begin
      if (pushFire) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/mpu_result_collector.sv
// ---------------------------------------------------------------------------
// mpu_result_collector
// Captures the 16-bit mpu result stream, packs consecutive results into
// 32-bit host words ({later, earlier}) and buffers them in a FWFT FIFO that
// the host drains via valid/ready. The mpu is never stalled: words that find
// the FIFO full are dropped and recorded in a sticky overflow flag.
//   clock, reset  system clock, synchronous active-high reset
//   bus           mpu_result_collector_if slave view (stream in, host out)
// ---------------------------------------------------------------------------
module mpu_result_collector
   import mpu_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input logic                  clock,
   input logic                  reset,
   mpu_result_collector_if.slave bus
);

   packState_e            state_q;
   packState_e            state_d;
   logic [MPU_DATA_W-1:0] loReg_q;
   logic [MPU_DATA_W-1:0] loReg_d;
   logic                  overflow_q;
   logic                  overflow_d;
   logic                  push;
   hostWord_t             pushWord;
   hostWord_t             headWord;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic                  dropped;

   mpu_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(hostWord_t))
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push),
      .wdata_i (pushWord),
      .pop_i   (bus.out_ready),
      .rdata_o (headWord),
      .level_o (bus.level),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   // Packer state, pending low half and sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= PK_LO;
         loReg_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         loReg_q    <= loReg_d;
         overflow_q <= overflow_d;
      end
   end

   // A result in LO is held unless flush asks for it immediately; any result
   // or flush in HI completes the word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         PK_LO: if (bus.send_in && !bus.flush) state_d = PK_HI;
         PK_HI: if (bus.send_in || bus.flush) state_d = PK_LO;
         default: state_d = PK_LO;
      endcase
   end

   // Builds the word to push and decides overflow. A full FIFO with the host
   // popping on the same edge still takes the word, so that is not a drop.
   always_comb begin
      push     = 1'b0;
      pushWord = '0;
      loReg_d  = loReg_q;
      case (state_q)
         PK_LO: begin
            if (bus.send_in && bus.flush) begin
               push     = 1'b1;
               pushWord = '{partial: 1'b1, data: {16'h0000, bus.data_in}};
            end else if (bus.send_in) begin
               loReg_d = bus.data_in;
            end
         end
         PK_HI: begin
            if (bus.send_in) begin
               push     = 1'b1;
               pushWord = '{partial: 1'b0, data: {bus.data_in, loReg_q}};
            end else if (bus.flush) begin
               push     = 1'b1;
               pushWord = '{partial: 1'b1, data: {16'h0000, loReg_q}};
            end
         end
         default: ;
      endcase
      dropped = push && fifoFull && !bus.out_ready;
      if (dropped) begin
         overflow_d = 1'b1;
      end else if (bus.clear_ovf) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      bus.out_valid   = !fifoEmpty;
      bus.out_data    = fifoEmpty ? '0 : headWord.data;
      bus.out_partial = fifoEmpty ? 1'b0 : headWord.partial;
      bus.overflow    = overflow_q;
   end

endmodule
